// File: rtl/crc16_pkg.sv
// Shared CRC16-CCITT definitions (x^16+x^12+x^5+1) used by the transmit
// generator and the receive check.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } crc16_state_e;

  // One serial step, MSB-first: shift left and fold the polynomial in on feedback.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// Serial CRC16 LFSR with synchronous load (priority) and shift enable;
// the whole register is exposed for the output mux and snapshot.
import crc16_pkg::*;

module crc16_lfsr #(
  parameter logic [15:0] PRESET = CRC16_PRESET
) (
  input  logic        crcinclk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge crcinclk or posedge reset) begin
    if (reset)       r_crc <= PRESET;
    else if (i_load) r_crc <= PRESET;
    else if (i_en)   r_crc <= crc16_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc16_tx_append.sv
// Transmit CRC16 appender: serial payload passthrough, then 16 CRC bits MSB first.
// Optional CRC16_TX_SNAPSHOT_EN adds crc_snap (final pre-inversion CRC of the last reply).
import crc16_pkg::*;

module crc16_tx_append #(
  parameter logic [15:0] PRESET     = CRC16_PRESET,
  parameter bit          INVERT_OUT = 1'b1
) (
  input  logic        crcinclk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        bitin,
  input  logic        bitin_valid,
  input  logic        data_last,
  output logic        bitout,
  output logic        bitout_valid,
  output logic        busy,
  output logic        done
`ifdef CRC16_TX_SNAPSHOT_EN
  ,
  output logic [15:0] crc_snap
`endif
);

  crc16_state_e r_state;
  logic [3:0]   r_cnt;
  logic         r_bitout;
  logic         r_bitout_valid;
  logic         r_busy;
  logic         r_done;

  logic [15:0]  w_crc;
  logic         w_load;
  logic         w_en;

  assign w_load = abort | ((r_state == IDLE) & start);
  assign w_en   = (r_state == DATA) & bitin_valid & ~abort;

  crc16_lfsr #(.PRESET(PRESET)) u_lfsr (
    .crcinclk (crcinclk),
    .reset    (reset),
    .i_load   (w_load),
    .i_en     (w_en),
    .i_bit    (bitin),
    .o_crc    (w_crc)
  );

  // done fires in the IDLE cycle that follows the last CRC bit; abort and reset
  // both clear bitout_valid, so only a completed CRC phase can raise it.
  always_ff @(posedge crcinclk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= 4'd0;
      r_bitout       <= 1'b0;
      r_bitout_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else if (abort) begin
      r_state        <= IDLE;
      r_bitout_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bitout_valid <= 1'b0;
          r_done         <= r_bitout_valid;
          if (start) begin
            r_state <= DATA;
            r_busy  <= 1'b1;
          end
        end
        DATA: begin
          r_done <= 1'b0;
          if (bitin_valid) begin
            r_bitout       <= bitin;
            r_bitout_valid <= 1'b1;
          end else begin
            r_bitout_valid <= 1'b0;
          end
          if (data_last) begin
            r_state <= CRC;
            r_cnt   <= 4'd15;
          end
        end
        CRC: begin
          r_done         <= 1'b0;
          r_bitout       <= w_crc[r_cnt] ^ INVERT_OUT;
          r_bitout_valid <= 1'b1;
          r_cnt          <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_bitout_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_done         <= 1'b0;
        end
      endcase
    end
  end

  assign bitout       = r_bitout;
  assign bitout_valid = r_bitout_valid;
  assign busy         = r_busy;
  assign done         = r_done;

`ifdef CRC16_TX_SNAPSHOT_EN
  logic [15:0] r_snap;

  always_ff @(posedge crcinclk or posedge reset) begin
    if (reset)
      r_snap <= 16'hFFFF;
    else if (!abort && (r_state == DATA) && data_last)
      r_snap <= bitin_valid ? crc16_step(w_crc, bitin) : w_crc;
  end

  assign crc_snap = r_snap;
`endif

endmodule

// File: tb/tb_crc16_tx_append.sv
// Scoreboard bench for crc16_tx_append: expected bits are queued at issue time
// from a polynomial long-division model and checked by an independent monitor.
module tb_crc16_tx_append;

  logic crcinclk = 1'b0;
  logic reset, start, abort, bitin, bitin_valid, data_last;
  logic bitout, bitout_valid, busy, done;

  crc16_tx_append dut (
    .crcinclk     (crcinclk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .bitin        (bitin),
    .bitin_valid  (bitin_valid),
    .data_last    (data_last),
    .bitout       (bitout),
    .bitout_valid (bitout_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 crcinclk = ~crcinclk;

  typedef struct {
    bit b;
    bit is_crc;
    bit last;
  } exp_t;

  exp_t sb[$];
  bit   obs[$];
  bit   payload[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  bit   exp_done_next = 1'b0;
  bit   crc_run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // CRC register after a bit stream = remainder of (S*x^16 + PRESET*x^n) mod G,
  // done here as plain long division over a bit array.
  function automatic logic [15:0] crc_model(input bit s[$]);
    bit a[$];
    logic [16:0] g;
    logic [15:0] pre;
    logic [15:0] r;
    int n;
    g   = 17'h11021;
    pre = 16'hFFFF;
    n   = s.size();
    a   = s;
    for (int j = 0; j < 16; j++) a.push_back(1'b0);
    for (int j = 0; j < 16; j++) a[j] = a[j] ^ pre[15-j];
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int k = 0; k <= 16; k++) a[i+k] = a[i+k] ^ g[16-k];
    for (int j = 0; j < 16; j++) r[15-j] = a[n+j];
    return r;
  endfunction

  task automatic push_crc();
    logic [15:0] tx;
    tx = ~crc_model(payload);
    for (int j = 15; j >= 0; j--) sb.push_back('{tx[j], 1'b1, (j == 0)});
  endtask

  task automatic tick();
    @(posedge crcinclk);
    #1;
  endtask

  function automatic logic [15:0] last16();
    logic [15:0] v;
    v = 16'h0;
    for (int j = 0; j < 16; j++) v[15-j] = obs[obs.size()-16+j];
    return v;
  endfunction

  // Monitor: pops the scoreboard on every valid output bit.
  always @(negedge crcinclk) begin
    if (!reset) begin
      if (exp_done_next) begin
        chk("done_pulse", {31'b0, done}, 32'd1);
        if (done) done_seen++;
        exp_done_next = 1'b0;
      end else if (done) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end
      if (done && bitout_valid) chk("done_and_valid", 32'd1, 32'd0);
      if (bitout_valid) begin
        exp_t e;
        obs.push_back(bitout);
        if (sb.size() == 0) begin
          chk("unexpected_bit", {31'b0, bitout_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(e.is_crc ? "crc_bit" : "payload_bit", {31'b0, bitout}, {31'b0, e.b});
          if (e.last) exp_done_next = 1'b1;
          crc_run = e.is_crc && !e.last;
        end
      end else if (crc_run) begin
        chk("crc_gap", {31'b0, bitout_valid}, 32'd1);
        crc_run = 1'b0;
      end
    end
  end

  // mode 0: normal, 1: start pulse during CRC, 2: async reset at cnt==7
  task automatic run_reply(input int gap_pct, input int mode);
    int d0;
    d0 = done_seen;
    obs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_in_data", {31'b0, busy}, 32'd1);
    if (payload.size() == 0) begin
      bitin_valid = 1'b0;
      data_last   = 1'b1;
      push_crc();
      tick();
    end else begin
      for (int i = 0; i < payload.size(); i++) begin
        while ($urandom_range(99) < gap_pct) begin
          bitin_valid = 1'b0;
          data_last   = 1'b0;
          bitin       = 1'($urandom);
          tick();
        end
        bitin       = payload[i];
        bitin_valid = 1'b1;
        data_last   = (i == payload.size() - 1);
        sb.push_back('{payload[i], 1'b0, 1'b0});
        if (data_last) push_crc();
        tick();
      end
    end
    bitin_valid = 1'b0;
    data_last   = 1'b0;
    if (mode == 1) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (mode == 2) begin
      repeat (8) tick();
      reset = 1'b1;
      sb.delete();
      exp_done_next = 1'b0;
      crc_run = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, bitout_valid}, 32'd0);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("after_rst_valid", {31'b0, bitout_valid}, 32'd0);
      return;
    end
    for (int k = 0; k < 40; k++) begin
      if (done_seen > d0) break;
      tick();
    end
    chk("done_count", done_seen - d0, 32'd1);
    repeat (2) tick();
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  task automatic load_123456789();
    logic [71:0] v;
    v = "123456789";
    payload.delete();
    for (int i = 0; i < 72; i++) payload.push_back(v[71-i]);
  endtask

  task automatic load_random(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(1'($urandom));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bitin = 1'b0; bitin_valid = 1'b0; data_last = 1'b0;
    #1;
    chk("rst_bitout", {31'b0, bitout}, 32'd0);
    chk("rst_valid", {31'b0, bitout_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(posedge crcinclk);
    #3 reset = 1'b0;
    tick();

    // ignored inputs in IDLE
    bitin_valid = 1'b1; data_last = 1'b1; bitin = 1'b1;
    tick();
    bitin_valid = 1'b0; data_last = 1'b0;
    tick();
    chk("idle_ignore_valid", {31'b0, bitout_valid}, 32'd0);

    load_123456789();
    run_reply(0, 0);
    chk("check_count", obs.size(), 32'd88);
    chk("check_crc", {16'b0, last16()}, 32'hD64E);

    payload.delete();
    run_reply(0, 0);
    chk("flush_count", obs.size(), 32'd16);
    chk("flush_crc", {16'b0, last16()}, 32'h0000);

    load_123456789();
    run_reply(40, 0);
    chk("gap_count", obs.size(), 32'd88);
    chk("gap_crc", {16'b0, last16()}, 32'hD64E);

    for (int r = 0; r < 20; r++) begin
      load_random($urandom_range(128, 1));
      run_reply(20, 0);
      chk("loopback_residue", {16'b0, crc_model(obs)}, 32'h1D0F);
    end

    // abort after bit 40
    load_random(41);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 41; i++) begin
      bitin = payload[i]; bitin_valid = 1'b1; data_last = 1'b0;
      sb.push_back('{payload[i], 1'b0, 1'b0});
      tick();
    end
    bitin_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", {31'b0, bitout_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_wins", {31'b0, busy}, 32'd0);
    tick();

    load_random(0);
    for (int i = 0; i < 16; i++) payload.push_back(1'b0);
    run_reply(0, 1);
    chk("post_abort_count", obs.size(), 32'd32);
    chk("post_abort_residue", {16'b0, crc_model(obs)}, 32'h1D0F);

    load_random(20);
    run_reply(0, 2);
    load_random(33);
    run_reply(10, 0);
    chk("post_reset_count", obs.size(), 32'd49);
    chk("post_reset_residue", {16'b0, crc_model(obs)}, 32'h1D0F);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
